// File: rtl/regfile_writeback_queue_pkg.sv
// Shared definitions for the register-file write-back path: default widths
// (matching the register file) and the queued {address, data} entry.
package regfile_writeback_queue_pkg;

    localparam int unsigned RF_DATA_WIDTH = 16;
    localparam int unsigned RF_ADDR_WIDTH = 8;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] address;
        logic [RF_DATA_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Producer, decode-query and RAM write-port signals of the write-back queue.
interface regfile_writeback_queue_if
    import regfile_writeback_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) ();

    logic                  iAluValid;
    logic [ADDR_WIDTH-1:0] iAluAddress;
    logic [DATA_WIDTH-1:0] iAluData;
    logic                  oAluReady;
    logic                  iMulValid;
    logic [ADDR_WIDTH-1:0] iMulAddress;
    logic [DATA_WIDTH-1:0] iMulData;
    logic                  oMulReady;
    logic [ADDR_WIDTH-1:0] iQueryAddress0;
    logic [ADDR_WIDTH-1:0] iQueryAddress1;
    logic                  oHazard0;
    logic                  oHazard1;
    logic                  oWriteEnable;
    logic [ADDR_WIDTH-1:0] oWriteAddress;
    logic [DATA_WIDTH-1:0] oWriteData;
    logic                  oEmpty;

    modport master (
        output iAluValid, iAluAddress, iAluData,
        output iMulValid, iMulAddress, iMulData,
        output iQueryAddress0, iQueryAddress1,
        input  oAluReady, oMulReady, oHazard0, oHazard1,
        input  oWriteEnable, oWriteAddress, oWriteData, oEmpty
    );

    modport slave (
        input  iAluValid, iAluAddress, iAluData,
        input  iMulValid, iMulAddress, iMulData,
        input  iQueryAddress0, iQueryAddress1,
        output oAluReady, oMulReady, oHazard0, oHazard1,
        output oWriteEnable, oWriteAddress, oWriteData, oEmpty
    );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// Circular buffer accepting up to two pushes (a before b) and one pop per edge,
// with two address-match ports covering only the occupied slots.
module regfile_writeback_fifo
    import regfile_writeback_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_a,
    input  entry_t                   entry_a,
    input  logic                     push_b,
    input  entry_t                   entry_b,
    input  logic                     pop,
    output entry_t                   head,
    output logic [CW-1:0]            count,
    input  logic [RF_ADDR_WIDTH-1:0] query0,
    input  logic [RF_ADDR_WIDTH-1:0] query1,
    output logic                     match0,
    output logic                     match1
);

    localparam int unsigned PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
            count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    // Storage is not reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push_a) mem[wr_ptr] <= entry_a;
            if (push_b) mem[wr_ptr + PW'(1)] <= entry_b;
        end
    end

    assign head = mem[rd_ptr];

    // A slot is occupied when its distance from the read pointer is below count.
    always_comb begin
        match0 = 1'b0;
        match1 = 1'b0;
        offset = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rd_ptr;
            if (CW'(offset) < count) begin
                if (mem[i].address == query0) match0 = 1'b1;
                if (mem[i].address == query1) match1 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-back queue: merges ALU and multiplier results (ALU first) into a FIFO
// drained one entry per cycle into registered RAM write-port outputs.
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 4
) (
    input logic                      Clock,
    input logic                      Reset,
    regfile_writeback_queue_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0]         count;
    logic [CW-1:0]         free;
    logic                  alu_ready;
    logic                  mul_ready;
    logic                  alu_push;
    logic                  mul_push;
    logic                  push_a;
    logic                  push_b;
    logic                  pop;
    entry_t                alu_entry;
    entry_t                mul_entry;
    entry_t                entry_a;
    entry_t                head;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;

    assign alu_entry = '{address: RF_ADDR_WIDTH'(bus.iAluAddress), data: RF_DATA_WIDTH'(bus.iAluData)};
    assign mul_entry = '{address: RF_ADDR_WIDTH'(bus.iMulAddress), data: RF_DATA_WIDTH'(bus.iMulData)};

    // Free space ignores a same-cycle pop; the multiplier yields the last slot to the ALU.
    always_comb begin
        free      = CW'(DEPTH) - count;
        alu_ready = !Reset && (free >= CW'(1));
        mul_ready = !Reset && ((free >= CW'(2)) || ((free == CW'(1)) && !bus.iAluValid));
        alu_push  = bus.iAluValid && alu_ready;
        mul_push  = bus.iMulValid && mul_ready;
        push_a    = alu_push || mul_push;
        push_b    = alu_push && mul_push;
        entry_a   = alu_push ? alu_entry : mul_entry;
        pop       = (count != '0);
    end

    regfile_writeback_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (Clock),
        .rst     (Reset),
        .push_a  (push_a),
        .entry_a (entry_a),
        .push_b  (push_b),
        .entry_b (mul_entry),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .query0  (RF_ADDR_WIDTH'(bus.iQueryAddress0)),
        .query1  (RF_ADDR_WIDTH'(bus.iQueryAddress1)),
        .match0  (bus.oHazard0),
        .match1  (bus.oHazard1)
    );

    // RAM write port; address and data hold their last values while idle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
        end else if (pop) begin
            write_enable  <= 1'b1;
            write_address <= ADDR_WIDTH'(head.address);
            write_data    <= DATA_WIDTH'(head.data);
        end else begin
            write_enable  <= 1'b0;
        end
    end

    assign bus.oAluReady     = alu_ready;
    assign bus.oMulReady     = mul_ready;
    assign bus.oWriteEnable  = write_enable;
    assign bus.oWriteAddress = write_address;
    assign bus.oWriteData    = write_data;
    assign bus.oEmpty        = Reset || ((count == '0) && !write_enable);

endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Write-back queue between the execution units and the dual-read-port register file RAM. It accepts results from two producers, the single-cycle ALU and the multi-cycle multiplier, into a small FIFO. It drains one entry per cycle into the RAM's single write port (write enable, write address, data in). It also reports read-after-write hazards to decode for destination registers still queued.

## Interface
Parameters:
- DATA_WIDTH, 16, width of a result word; matches the register file.
- ADDR_WIDTH, 8, width of a register address; matches the register file.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- iAluValid  in  1  ALU result present this cycle.
- iAluAddress  in  ADDR_WIDTH  ALU destination register.
- iAluData  in  DATA_WIDTH  ALU result.
- oAluReady  out  1  ALU result accepted this cycle if valid.
- iMulValid  in  1  multiplier result present this cycle.
- iMulAddress  in  ADDR_WIDTH  multiplier destination register.
- iMulData  in  DATA_WIDTH  multiplier result.
- oMulReady  out  1  multiplier result accepted this cycle if valid.
- iQueryAddress0  in  ADDR_WIDTH  decode source operand 0.
- iQueryAddress1  in  ADDR_WIDTH  decode source operand 1.
- oHazard0  out  1  iQueryAddress0 matches a queued entry.
- oHazard1  out  1  iQueryAddress1 matches a queued entry.
- oWriteEnable  out  1  to RAM iWriteEnable, registered.
- oWriteAddress  out  ADDR_WIDTH  to RAM iWriteAddress, registered.
- oWriteData  out  DATA_WIDTH  to RAM iDataIn, registered.
- oEmpty  out  1  FIFO empty and no write in flight.

## Operation
- Storage: circular FIFO of {address, data}; read pointer, write pointer, count in 0..DEPTH.
- Free slots: free = DEPTH - count, using the count before this edge. A same-cycle pop does not credit free.
- ALU acceptance:
  - oAluReady = (free >= 1) && !Reset.
  - Accepted when iAluValid && oAluReady.
- Multiplier acceptance:
  - oMulReady = !Reset && (free >= 2 || (free == 1 && !iAluValid)).
  - The ALU has priority.
- Push order on a same-cycle double push: ALU entry first, then multiplier entry. Up to 2 pushes per edge.
- Pop: at each edge, if count > 0, the head is popped into the output registers and oWriteEnable <= 1. Otherwise oWriteEnable <= 0; address and data hold their last values.
- Count update: count <= count + pushes - pop. Pointers wrap modulo DEPTH.
- Hazards:
  - oHazardN is combinational: OR over valid FIFO entries of (entry address == iQueryAddressN).
  - The output register stage is excluded, because the RAM's own write-to-read bypass covers it.
  - Same-cycle incoming inputs are excluded.
- oEmpty = (count == 0) && !oWriteEnable.
- Duplicate destinations are kept in order; the RAM ends up with the later value.
- Reset has priority over all pushes and pops. Reset mid-operation discards queued entries without writing them.

## Timing
- Reset values: count 0, pointers 0, oWriteEnable 0, oWriteAddress 0, oWriteData 0. While Reset is high, oAluReady = 0, oMulReady = 0 and oEmpty = 1.
- Latency: an entry pushed at edge N into an empty FIFO is popped at edge N+1. oWriteEnable is high in the cycle following edge N+1, and the RAM commits it at edge N+2.
- Throughput: one RAM write per cycle sustained. Two producers pushing every cycle fill the FIFO, after which the multiplier is back-pressured.
- Ready signals depend combinationally on iAluValid only, never on iMulValid.

## Structure
- Shared package: DATA_WIDTH and ADDR_WIDTH defaults, shared with the register file, and the queue entry struct typedef {address, data}.
- One sub-module is natural: regfile_writeback_fifo, a 2-push/1-pop circular buffer with an entry-address match port. The top level holds the acceptance logic and output registers.

## Test plan
- Reset mid-stream with 3 entries queued -> next cycle count 0, oWriteEnable 0, oEmpty 1, no further RAM writes.
- Single ALU push addr 5, data 0x1234, at edge N -> oWriteEnable=1, oWriteAddress=5, oWriteData=0x1234 in the cycle after edge N+1; oHazard0 with query 5 is high only during the cycle the entry sits in the FIFO.
- Same-cycle ALU (addr 2, 0xAAAA) and MUL (addr 3, 0xBBBB) pushes -> RAM writes addr 2 then addr 3 on consecutive cycles.
- Both producers valid every cycle, DEPTH=4 -> oMulReady drops once free < 2; no entry lost or reordered; ALU never stalls.
- Full FIFO (count 4), ALU valid -> oAluReady=0; after one pop, ready returns the following cycle.
- Two entries to addr 7 (0x0001 then 0x0002) -> the RAM read of addr 7 after draining returns 0x0002.
